// File: rtl/ps2_ascii_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_ascii_decoder
// Description : PS/2 Set-2 scan-code to ASCII translator. Tracks the E0/F0
//               prefixes, shift and caps-lock state, and queues one ASCII byte
//               per key press in a small valid/ready output FIFO.
//               Optional feature macro: PS2_ASCII_CAPSLOCK_EN enables the
//               caps-lock toggle. Without it, caps_active is held at 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_ascii_decoder #(
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] UNKNOWN_CHAR = 8'h2A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    output logic [7:0] ascii_out,
    output logic       ascii_valid,
    input  logic       ascii_ready,
    output logic       shift_active,
    output logic       caps_active,
    output logic       overflow
);

    localparam int                C_AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                C_CW       = C_AW + 1;
    localparam logic [C_CW-1:0]   C_FULL_CNT = C_CW'(FIFO_DEPTH);
    localparam logic [C_AW-1:0]   C_PTR_ONE  = C_AW'(1);
    localparam logic [C_CW-1:0]   C_CNT_ONE  = C_CW'(1);

    localparam logic [7:0] C_E0     = 8'hE0;
    localparam logic [7:0] C_F0     = 8'hF0;
    localparam logic [7:0] C_LSHIFT = 8'h12;
    localparam logic [7:0] C_RSHIFT = 8'h59;
    localparam logic [7:0] C_CAPS   = 8'h58;
    localparam logic [7:0] C_ENTER  = 8'h5A;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_EXT       = 2'd1,
        S_BREAK     = 2'd2,
        S_EXT_BREAK = 2'd3
    } state_t;

    logic [1:0]      r_rst_sync;
    logic            w_rst_n;
    state_t          r_state;
    logic            r_lshift;
    logic            r_rshift;
    logic            r_caps;
`ifdef PS2_ASCII_CAPSLOCK_EN
    logic            r_caps_held;
`endif

    logic            w_is_ctrl;
    logic            w_is_letter;
    logic [4:0]      w_letter_idx;
    logic            w_is_digit;
    logic [3:0]      w_digit_val;
    logic [7:0]      w_sym_char;
    logic            w_mk_push;
    logic [7:0]      w_mk_char;
    logic            w_push;
    logic [7:0]      w_char;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [C_AW-1:0] r_wr_ptr;
    logic [C_AW-1:0] r_rd_ptr;
    logic [C_CW-1:0] r_count;
    logic            r_overflow;
    logic            w_pop;
    logic            w_full;
    logic            w_wr_en;

    // Reset conditioning: assert asynchronously, release on a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    // Classify the incoming byte: controller byte, letter index, digit value
    always_comb begin
        w_is_ctrl    = (code_in == 8'hAA) || (code_in == 8'hFA) || (code_in == 8'hEE) ||
                       (code_in == 8'hFE) || (code_in == 8'hE1);
        w_is_letter  = 1'b1;
        w_letter_idx = 5'd0;
        case (code_in)
            8'h1C: w_letter_idx = 5'd0;   8'h32: w_letter_idx = 5'd1;
            8'h21: w_letter_idx = 5'd2;   8'h23: w_letter_idx = 5'd3;
            8'h24: w_letter_idx = 5'd4;   8'h2B: w_letter_idx = 5'd5;
            8'h34: w_letter_idx = 5'd6;   8'h33: w_letter_idx = 5'd7;
            8'h43: w_letter_idx = 5'd8;   8'h3B: w_letter_idx = 5'd9;
            8'h42: w_letter_idx = 5'd10;  8'h4B: w_letter_idx = 5'd11;
            8'h3A: w_letter_idx = 5'd12;  8'h31: w_letter_idx = 5'd13;
            8'h44: w_letter_idx = 5'd14;  8'h4D: w_letter_idx = 5'd15;
            8'h15: w_letter_idx = 5'd16;  8'h2D: w_letter_idx = 5'd17;
            8'h1B: w_letter_idx = 5'd18;  8'h2C: w_letter_idx = 5'd19;
            8'h3C: w_letter_idx = 5'd20;  8'h2A: w_letter_idx = 5'd21;
            8'h1D: w_letter_idx = 5'd22;  8'h22: w_letter_idx = 5'd23;
            8'h35: w_letter_idx = 5'd24;  8'h1A: w_letter_idx = 5'd25;
            default: w_is_letter = 1'b0;
        endcase
        w_is_digit  = 1'b1;
        w_digit_val = 4'd0;
        case (code_in)
            8'h45: w_digit_val = 4'd0;  8'h16: w_digit_val = 4'd1;
            8'h1E: w_digit_val = 4'd2;  8'h26: w_digit_val = 4'd3;
            8'h25: w_digit_val = 4'd4;  8'h2E: w_digit_val = 4'd5;
            8'h36: w_digit_val = 4'd6;  8'h3D: w_digit_val = 4'd7;
            8'h3E: w_digit_val = 4'd8;  8'h46: w_digit_val = 4'd9;
            default: w_is_digit = 1'b0;
        endcase
    end

    // Shifted digit symbols: ) ! @ # $ % ^ & * (
    always_comb begin
        w_sym_char = 8'h29;
        case (w_digit_val)
            4'd1:    w_sym_char = 8'h21;
            4'd2:    w_sym_char = 8'h40;
            4'd3:    w_sym_char = 8'h23;
            4'd4:    w_sym_char = 8'h24;
            4'd5:    w_sym_char = 8'h25;
            4'd6:    w_sym_char = 8'h5E;
            4'd7:    w_sym_char = 8'h26;
            4'd8:    w_sym_char = 8'h2A;
            4'd9:    w_sym_char = 8'h28;
            default: w_sym_char = 8'h29;
        endcase
    end

    // Translate a plain make code using the shift/caps state held before this byte
    always_comb begin
        w_mk_push = 1'b1;
        w_mk_char = UNKNOWN_CHAR;
        if (w_is_letter) begin
            w_mk_char = ((shift_active ^ caps_active) ? 8'h41 : 8'h61) + {3'b000, w_letter_idx};
        end else if (w_is_digit) begin
            w_mk_char = shift_active ? w_sym_char : (8'h30 + {4'b0000, w_digit_val});
        end else begin
            case (code_in)
                8'h29:                      w_mk_char = 8'h20;
                C_ENTER:                    w_mk_char = 8'h0D;
                8'h66:                      w_mk_char = 8'h08;
                C_LSHIFT, C_RSHIFT, C_CAPS: w_mk_push = 1'b0;
                default:                    w_mk_char = UNKNOWN_CHAR;
            endcase
        end
    end

    // Decide whether this byte produces a character given the prefix state
    always_comb begin
        w_push = 1'b0;
        w_char = w_mk_char;
        if (code_valid && !w_is_ctrl && (code_in != C_E0)) begin
            case (r_state)
                S_IDLE: begin
                    if (code_in != C_F0) begin
                        w_push = w_mk_push;
                    end
                end
                S_EXT: begin
                    if (code_in == C_ENTER) begin
                        w_push = 1'b1;
                        w_char = 8'h0D;
                    end
                end
                default: w_push = 1'b0;
            endcase
        end
    end

    // Prefix state machine plus shift/caps modifier tracking
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state  <= S_IDLE;
            r_lshift <= 1'b0;
            r_rshift <= 1'b0;
`ifdef PS2_ASCII_CAPSLOCK_EN
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
`endif
        end else if (code_valid) begin
            if (w_is_ctrl) begin
                r_state <= S_IDLE;
            end else if (code_in == C_E0) begin
                r_state <= S_EXT;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (code_in == C_F0) begin
                            r_state <= S_BREAK;
                        end else begin
                            if (code_in == C_LSHIFT) r_lshift <= 1'b1;
                            if (code_in == C_RSHIFT) r_rshift <= 1'b1;
`ifdef PS2_ASCII_CAPSLOCK_EN
                            // Auto-repeat of caps must not toggle again
                            if ((code_in == C_CAPS) && !r_caps_held) begin
                                r_caps      <= ~r_caps;
                                r_caps_held <= 1'b1;
                            end
`endif
                        end
                    end
                    S_EXT: begin
                        r_state <= (code_in == C_F0) ? S_EXT_BREAK : S_IDLE;
                    end
                    S_BREAK: begin
                        if (code_in == C_LSHIFT) r_lshift <= 1'b0;
                        if (code_in == C_RSHIFT) r_rshift <= 1'b0;
`ifdef PS2_ASCII_CAPSLOCK_EN
                        if (code_in == C_CAPS) r_caps_held <= 1'b0;
`endif
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifndef PS2_ASCII_CAPSLOCK_EN
    assign r_caps = 1'b0;
`endif

    assign shift_active = r_lshift | r_rshift;
    assign caps_active  = r_caps;

    assign ascii_valid = (r_count != '0);
    assign w_pop       = ascii_valid & ascii_ready;
    assign w_full      = (r_count == C_FULL_CNT);
    assign w_wr_en     = w_push & (~w_full | w_pop);
    assign ascii_out   = ascii_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign overflow    = r_overflow;

    // Queue storage; slot contents are only observed while counted as valid
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_char;
        end
    end

    // Queue pointers, occupancy and the drop indicator
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push & w_full & ~w_pop;
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_ascii_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_ascii_decoder
// Description : Self-checking bench for ps2_ascii_decoder. Directed key
//               sequences plus random byte streams with a random consumer,
//               compared every cycle against a key-level reference model.
//               Honours PS2_ASCII_CAPSLOCK_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_ascii_decoder;

    localparam int FIFO_DEPTH = 4;
    localparam logic [7:0] UNKNOWN_CHAR = 8'h2A;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] code_in = 8'h00;
    logic       code_valid = 1'b0;
    logic [7:0] ascii_out;
    logic       ascii_valid;
    logic       ascii_ready = 1'b1;
    logic       shift_active;
    logic       caps_active;
    logic       overflow;

    ps2_ascii_decoder #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .UNKNOWN_CHAR (UNKNOWN_CHAR)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .code_in      (code_in),
        .code_valid   (code_valid),
        .ascii_out    (ascii_out),
        .ascii_valid  (ascii_valid),
        .ascii_ready  (ascii_ready),
        .shift_active (shift_active),
        .caps_active  (caps_active),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_ovf = 0;

    // Reference model: what a keyboard user would expect to see
    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] symbols [10] = '{")", "!", "@", "#", "$", "%", "^", "&", "*", "("};

    logic [7:0] m_q   [$];
    logic [7:0] m_pfx [$];
    bit         m_lshift, m_rshift, m_caps, m_caps_held;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int translate(input logic [7:0] c, input bit sh, input bit cp);
        if (c == 8'h12 || c == 8'h59 || c == 8'h58) return -1;
        for (int i = 0; i < 26; i++)
            if (letters[i] == c) return (sh ^ cp) ? ("A" + i) : ("a" + i);
        for (int i = 0; i < 10; i++)
            if (digits[i] == c) return sh ? int'(symbols[i]) : ("0" + i);
        if (c == 8'h29) return 8'h20;
        if (c == 8'h5A) return 8'h0D;
        if (c == 8'h66) return 8'h08;
        return int'(UNKNOWN_CHAR);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pfx.delete();
        m_lshift = 0; m_rshift = 0; m_caps = 0; m_caps_held = 0;
    endtask

    task automatic model_byte(input logic [7:0] c, output int ch);
        bit ext, brk;
        ch = -1;
        if (c inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hE1}) begin
            m_pfx.delete();
            return;
        end
        if (c == 8'hE0) begin
            m_pfx.delete();
            m_pfx.push_back(c);
            return;
        end
        brk = 0; ext = 0;
        foreach (m_pfx[i]) begin
            if (m_pfx[i] == 8'hF0) brk = 1;
            if (m_pfx[i] == 8'hE0) ext = 1;
        end
        if (c == 8'hF0 && !brk) begin
            m_pfx.push_back(c);
            return;
        end
        m_pfx.delete();
        if (ext && brk) return;
        if (ext) begin
            if (c == 8'h5A) ch = 8'h0D;
            return;
        end
        if (brk) begin
            if (c == 8'h12) m_lshift = 0;
            if (c == 8'h59) m_rshift = 0;
            if (c == 8'h58) m_caps_held = 0;
            return;
        end
        if (c == 8'h12) m_lshift = 1;
        if (c == 8'h59) m_rshift = 1;
`ifdef PS2_ASCII_CAPSLOCK_EN
        if (c == 8'h58 && !m_caps_held) begin
            m_caps = !m_caps;
            m_caps_held = 1;
        end
`endif
        ch = translate(c, m_lshift | m_rshift, m_caps);
    endtask

    // One clock: apply inputs, advance model across the edge, compare outputs
    task automatic step(input bit v, input logic [7:0] c, input bit rdy);
        int  ch;
        bit  pop, exp_ovf;
        code_valid  = v;
        code_in     = c;
        ascii_ready = rdy;
        @(posedge clk);
        pop = (m_q.size() != 0) && rdy;
        ch  = -1;
        if (v) model_byte(c, ch);
        exp_ovf = 0;
        if (pop) void'(m_q.pop_front());
        if (ch >= 0) begin
            if (m_q.size() < FIFO_DEPTH) m_q.push_back(ch[7:0]);
            else exp_ovf = 1;
        end
        #1;
        check_value("ascii_valid", 32'(ascii_valid), 32'(m_q.size() != 0));
        check_value("ascii_out", 32'(ascii_out), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
        check_value("overflow", 32'(overflow), 32'(exp_ovf));
        check_value("shift_active", 32'(shift_active), 32'(m_lshift | m_rshift));
        check_value("caps_active", 32'(caps_active), 32'(m_caps));
        if (overflow) n_ovf++;
        code_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] c);
        step(1'b1, c, 1'b1);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy);
    endtask

    task automatic do_reset();
        code_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_value("rst_ascii_valid", 32'(ascii_valid), 32'h0);
        check_value("rst_ascii_out", 32'(ascii_out), 32'h0);
        check_value("rst_overflow", 32'(overflow), 32'h0);
        check_value("rst_shift", 32'(shift_active), 32'h0);
        check_value("rst_caps", 32'(caps_active), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle(3, 1'b1);
    endtask

    initial begin
        int ovf0;
        logic [7:0] c;
        int sel;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Make/break of a single letter
        send(8'h1C); send(8'hF0); send(8'h1C); idle(2, 1'b1);

        // Shift held around a letter
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h12); send(8'h1C); idle(2, 1'b1);

        // Caps-lock with repeat, then shift
        send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); idle(2, 1'b1);

        // Shifted digits, extended keys, unknown code
        send(8'h59); send(8'h1E); send(8'h45); send(8'hF0); send(8'h59);
        send(8'hE0); send(8'h5A); send(8'hE0); send(8'h75); send(8'h0E);
        send(8'h29); send(8'h66); send(8'h16); send(8'hE0); send(8'hF0); send(8'h12);
        idle(3, 1'b1);

        // Overflow with a stalled consumer, then drain
        ovf0 = n_ovf;
        step(1'b1, 8'h1C, 1'b0); step(1'b1, 8'h32, 1'b0); step(1'b1, 8'h21, 1'b0);
        step(1'b1, 8'h23, 1'b0); step(1'b1, 8'h24, 1'b0);
        idle(1, 1'b0);
        check_value("ovf_pulses", 32'(n_ovf - ovf0), 32'd1);
        idle(5, 1'b1);
        check_value("drained_valid", 32'(ascii_valid), 32'h0);

        // Full queue with simultaneous pop accepts the push
        for (int i = 0; i < 4; i++) step(1'b1, letters[i + 5], 1'b0);
        step(1'b1, 8'h1A, 1'b1);
        idle(6, 1'b1);

        // Reset in the middle of a break prefix
        send(8'h12);
        send(8'hF0);
        do_reset();
        send(8'h1C); idle(2, 1'b1);

        // Random byte stream with a random consumer
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: c = letters[$urandom_range(0, 25)];
                4:          c = digits[$urandom_range(0, 9)];
                5:          c = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
                6:          c = ($urandom_range(0, 1) != 0) ? 8'hF0 : 8'hE0;
                7: begin
                    case ($urandom_range(0, 3))
                        0:       c = 8'h58;
                        1:       c = 8'h29;
                        2:       c = 8'h5A;
                        default: c = 8'h66;
                    endcase
                end
                8: begin
                    case ($urandom_range(0, 4))
                        0:       c = 8'hAA;
                        1:       c = 8'hFA;
                        2:       c = 8'hEE;
                        3:       c = 8'hFE;
                        default: c = 8'hE1;
                    endcase
                end
                default:    c = 8'($urandom_range(0, 255));
            endcase
            step($urandom_range(0, 99) < 70, c, $urandom_range(0, 99) < 55);
            if (n == 1500) do_reset();
        end
        idle(8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_ascii_decoder.md
# ps2_ascii_decoder

Stateful PS/2 Set-2 scan-code to ASCII translator with a buffered valid/ready output. Sits between the PS/2 byte receiver and the processor's keyboard input port. Tracks make/break and extended prefixes plus shift/caps-lock state, and emits one ASCII byte per key press. Results are queued in a parametrised FIFO so the consumer may stall.

## Interface
- `FIFO_DEPTH`, default 4: output queue entries; power of two, ≥2.
- `UNKNOWN_CHAR`, default 8'h2A: ASCII emitted for an unmapped make code ('*').

- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `code_in`  in  8  received PS/2 byte.
- `code_valid`  in  1  one-cycle strobe; `code_in` is valid this cycle.
- `ascii_out`  out  8  FIFO head byte; 8'h00 when empty.
- `ascii_valid`  out  1  FIFO non-empty.
- `ascii_ready`  in  1  consumer accepts head when `ascii_valid & ascii_ready`.
- `shift_active`  out  1  left (12) or right (59) shift held.
- `caps_active`  out  1  caps-lock toggle state.
- `overflow`  out  1  one-cycle pulse when a character is dropped because the FIFO is full.

## Operation
- Prefix FSM, advanced only on `code_valid`:
  - IDLE: F0→BREAK; E0→EXT; else process make code, stay IDLE.
  - EXT: F0→EXT_BREAK; else process extended make, →IDLE.
  - BREAK: process break code, →IDLE.
  - EXT_BREAK: discard byte, →IDLE.
  - E0 from any state→EXT.
  - Controller bytes AA, FA, EE, FE, E1 in any state: no output, →IDLE.
- Make-code processing:
  - 12/59: set that shift's held flag; no output.
  - 58: caps-lock (see Configuration); no output.
  - Letters (A=1C … Z=1A, Set-2 map): uppercase (41–5A) if `shift_active ^ caps_active`, else lowercase (61–7A).
  - Digits 45,16,1E,26,25,2E,36,3D,3E,46 (0–9):
    - unshifted: 30–39.
    - shifted: `)!@#$%^&*(`, i.e. 29,21,40,23,24,25,5E,26,2A,28.
  - 29→20, 5A→0D, 66→08; independent of shift.
  - Any other code→`UNKNOWN_CHAR`.
- Extended make: only E0 5A→0D; all others produce no output.
- Break processing: 12/59 clear that shift's held flag; 58 clears caps-held; all others are ignored. Break never produces output.
- Typematic repeat of a make code emits the character again.
- FIFO push on translated char; pop on `ascii_valid & ascii_ready`.
  - Full with pop in the same cycle: push accepted.
  - Full without pop: char dropped, `overflow` pulses, contents unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`; count is `$clog2(FIFO_DEPTH)+1` bits.

## Timing
- Reset (async assert, sync deassert internally):
  - FSM to IDLE; shift, caps and held flags cleared; FIFO emptied.
  - `ascii_out`=00, `ascii_valid`=0, `overflow`=0, `shift_active`=0, `caps_active`=0.
- Latency: character strobed at edge N is on `ascii_out` with `ascii_valid`=1 after edge N, provided the FIFO was empty.
- Pop of head at edge N: next entry (or 00 with `ascii_valid` low) is presented after edge N.
- `shift_active`/`caps_active` update at the edge consuming the byte. A letter in the byte after 12 already sees shift.
- Reset mid-prefix (after F0/E0) discards the prefix; the next byte is treated as a make code.
- `code_valid` strobes may arrive on consecutive cycles; every one is processed.

## Configuration
- `PS2_ASCII_CAPSLOCK_EN` defined:
  - Make 58 while caps-held=0 toggles caps and sets caps-held (repeats do not retoggle).
  - Break 58 clears caps-held.
- Not defined:
  - `caps_active` is tied 0; make/break 58 is consumed silently (no `UNKNOWN_CHAR`).
  - Letter case depends on shift only.

## Test plan
- Reset, then bytes 1C, F0, 1C with `ascii_ready`=1 → single 61 ('a'); break emits nothing.
- 12, 1C, F0 1C, F0 12, 1C → 41 then 61; `shift_active` high only between 12 and F0 12.
- With `PS2_ASCII_CAPSLOCK_EN`: 58, 58 (repeat), F0 58, 12, 1C → `caps_active`=1, output 61 (caps^shift). Without the macro: same stimulus → 41.
- Shifted digits: 59, 1E, 45 → 40, 29; E0 5A → 0D; E0 75 → no output; 0E → 2A.
- `ascii_ready`=0 with FIFO_DEPTH=4, five letter makes → first four queued, fifth dropped with one `overflow` pulse. Then `ascii_ready`=1 drains the four in order, and `ascii_valid` falls after the fourth pop.
- F0 strobed, then `rst_n` pulsed low, then 1C → 61 emitted; the F0 prefix is lost and FIFO and flags are at reset values.
